// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding a UART transmit datapath: grants one frame at a time,
// holds the winner's byte and parity select, then paces the frame and gap on BaudTick.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (A wins ties) instead of round-robin.
module uart_tx_arbiter #(
  parameter int unsigned FRAME_BITS = 11,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       BaudTick,
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic [7:0] DinA,
  input  logic [7:0] DinB,
  input  logic       ParA,
  input  logic       ParB,
  output logic [7:0] Dout,
  output logic       ParityOut,
  output logic       Load,
  output logic       Select,
  output logic       GntA,
  output logic       GntB,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

  localparam logic [3:0] FrameLast = 4'(FRAME_BITS - 1);
  localparam logic [3:0] GapLast   = 4'(GAP_TICKS - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       last_b_q;  // identity of the current/last owner: 1 = B
  logic       pick_b;

  always_comb begin
    pick_b = 1'b0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    pick_b = ReqB & ~ReqA;
`else
    pick_b = ReqB & (~ReqA | ~last_b_q);
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      last_b_q  <= 1'b1;
      Dout      <= 8'h00;
      ParityOut <= 1'b0;
      Load      <= 1'b0;
      Select    <= 1'b0;
      GntA      <= 1'b0;
      GntB      <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Load <= 1'b0;
      GntA <= 1'b0;
      GntB <= 1'b0;
      Done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ReqA || ReqB) begin
            state_q   <= StLoad;
            Dout      <= pick_b ? DinB : DinA;
            ParityOut <= pick_b ? ParB : ParA;
            last_b_q  <= pick_b;
            Load      <= 1'b1;
            GntA      <= ~pick_b;
            GntB      <= pick_b;
            Select    <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        StLoad: begin
          state_q <= StShift;
          cnt_q   <= 4'd0;
        end
        StShift: begin
          if (BaudTick) begin
            if (cnt_q == FrameLast) begin
              cnt_q <= 4'd0;
              if (GAP_TICKS == 0) begin
                state_q <= StIdle;
                Done    <= 1'b1;
                Select  <= 1'b0;
                Busy    <= 1'b0;
              end else begin
                state_q <= StGap;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        StGap: begin
          if (BaudTick) begin
            if (cnt_q == GapLast) begin
              cnt_q   <= 4'd0;
              state_q <= StIdle;
              Done    <= 1'b1;
              Select  <= 1'b0;
              Busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default instance plus a GAP_TICKS=0 instance.
module tb_uart_tx_arbiter;

  logic       Clk, Rst, BaudTick;
  logic       ReqA, ReqB, ParA, ParB;
  logic [7:0] DinA, DinB;
  logic [7:0] Dout;
  logic       ParityOut, Load, Select, GntA, GntB, Busy, Done;
  logic       ReqA2, ReqB2;
  logic [7:0] Dout2;
  logic       ParityOut2, Load2, Select2, GntA2, GntB2, Busy2, Done2;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter dut (
    .Clk(Clk), .Rst(Rst), .BaudTick(BaudTick), .ReqA(ReqA), .ReqB(ReqB),
    .DinA(DinA), .DinB(DinB), .ParA(ParA), .ParB(ParB), .Dout(Dout),
    .ParityOut(ParityOut), .Load(Load), .Select(Select), .GntA(GntA), .GntB(GntB),
    .Busy(Busy), .Done(Done)
  );

  uart_tx_arbiter #(.FRAME_BITS(11), .GAP_TICKS(0)) dut_gap0 (
    .Clk(Clk), .Rst(Rst), .BaudTick(BaudTick), .ReqA(ReqA2), .ReqB(ReqB2),
    .DinA(DinA), .DinB(DinB), .ParA(ParA), .ParB(ParB), .Dout(Dout2),
    .ParityOut(ParityOut2), .Load(Load2), .Select(Select2), .GntA(GntA2), .GntB(GntB2),
    .Busy(Busy2), .Done(Done2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse();
    BaudTick = 1'b1;
    step();
    BaudTick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100; c++) begin
      if (!Busy) break;
      BaudTick = ~BaudTick;
      step();
    end
    BaudTick = 1'b0;
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: Busy=%b want 0", Busy);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    Rst = 1'b0; BaudTick = 1'b0; ReqA = 0; ReqB = 0; ReqA2 = 0; ReqB2 = 0;
    DinA = 8'h00; DinB = 8'h00; ParA = 0; ParB = 0;
    step();
    got = {Dout, ParityOut, Load, Select, GntA, GntB, Busy, Done, 1'b0};
    checks++;
    if (got !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000", got);
    end
    Rst = 1'b1;
    step();
    checks++;
    if (Busy !== 1'b0 || Load !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: Busy=%b Load=%b want 0 0", Busy, Load);
    end
  endtask

  task automatic test_single();
    ReqA = 1; DinA = 8'hA5; ParA = 1;
    step();
    checks++;
    if ({Load, GntA, GntB, Dout, ParityOut, Select, Busy, Done} !== {3'b110, 8'hA5, 4'b1110}) begin
      errors++;
      $display("FAIL single_load: L=%b GA=%b GB=%b D=%h P=%b S=%b B=%b Dn=%b want 1 1 0 a5 1 1 1 0",
               Load, GntA, GntB, Dout, ParityOut, Select, Busy, Done);
    end
    ReqA = 0;
    step();
    checks++;
    if (Load !== 1'b0 || GntA !== 1'b0) begin
      errors++;
      $display("FAIL single_load_len: Load=%b GntA=%b want 0 0", Load, GntA);
    end
    for (int i = 1; i <= 12; i++) begin
      pulse();
      if (i == 11) begin
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b1) begin
          errors++;
          $display("FAIL single_early_done: Done=%b Busy=%b want 0 1", Done, Busy);
        end
      end
      if (i < 12) step();
    end
    checks++;
    if ({Done, Busy, Select, Load, GntA} !== 5'b10000) begin
      errors++;
      $display("FAIL single_done: Dn=%b B=%b S=%b L=%b GA=%b want 1 0 0 0 0",
               Done, Busy, Select, Load, GntA);
    end
    step();
    checks++;
    if (Done !== 1'b0 || Dout !== 8'hA5) begin
      errors++;
      $display("FAIL single_after: Done=%b Dout=%h want 0 a5", Done, Dout);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] seen [4];
    logic [7:0] exp_d;
    int n = 0;
    int overlap = 0;
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    ReqA = 1; ReqB = 1; DinA = 8'h11; DinB = 8'h22;
    for (int c = 0; c < 300 && n < 4; c++) begin
      BaudTick = (c % 2 == 1);
      step();
      if (Done && (Load || GntA || GntB)) overlap++;
      if (Load) begin
        seen[n] = Dout;
        n++;
      end
    end
    BaudTick = 0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL rr_loads: got %0d loads want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      exp_d = 8'h11;
`else
      exp_d = (i % 2 == 1) ? 8'h22 : 8'h11;
`endif
      checks++;
      if (i < n && seen[i] !== exp_d) begin
        errors++;
        $display("FAIL rr_order[%0d]: Dout=%h want %h", i, seen[i], exp_d);
      end
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL rr_overlap: %0d cycles with Done and Load/Gnt, want 0", overlap);
    end
    ReqA = 0; ReqB = 0;
    wait_idle();
  endtask

  task automatic test_mid_frame();
    int  gntb_seen = 0;
    int  dout_bad = 0;
    logic got_done = 0;
    ReqA = 1; DinA = 8'h33; ParA = 0;
    step();
    checks++;
    if (Load !== 1'b1 || Dout !== 8'h33) begin
      errors++;
      $display("FAIL mid_load: Load=%b Dout=%h want 1 33", Load, Dout);
    end
    ReqA = 0;
    step();
    for (int c = 0; c < 100; c++) begin
      BaudTick = (c % 2 == 0);
      ReqB = (c % 3 == 0);
      DinA = 8'hFF;
      step();
      if (GntB) gntb_seen++;
      if (Dout !== 8'h33) dout_bad++;
      if (Done) begin
        got_done = 1;
        break;
      end
    end
    checks++;
    if (got_done !== 1'b1 || gntb_seen !== 0 || dout_bad !== 0) begin
      errors++;
      $display("FAIL mid_hold: done=%b gntb=%0d dout_bad=%0d want 1 0 0",
               got_done, gntb_seen, dout_bad);
    end
    ReqB = 1; DinB = 8'h44; ParB = 1; BaudTick = 0;
    step();
    checks++;
    if ({GntB, GntA, Load, Dout, ParityOut} !== {3'b101, 8'h44, 1'b1}) begin
      errors++;
      $display("FAIL mid_regrant: GB=%b GA=%b L=%b D=%h P=%b want 1 0 1 44 1",
               GntB, GntA, Load, Dout, ParityOut);
    end
    ReqB = 0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    ReqA = 1; DinA = 8'h5A; ParA = 1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      pulse();
      step();
    end
    Rst = 1'b0;
    #1;
    got = {Dout, ParityOut, Load, Select, GntA, GntB, Busy, Done, 1'b0};
    checks++;
    if (got !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_async: got %h want 0000", got);
    end
    step();
    checks++;
    if (Load !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_held: Load=%b Done=%b want 0 0", Load, Done);
    end
    Rst = 1'b1;
    step();
    checks++;
    if ({Load, GntA, Dout, Done} !== {2'b11, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_regrant: L=%b GA=%b D=%h Dn=%b want 1 1 5a 0",
               Load, GntA, Dout, Done);
    end
    ReqA = 0;
    wait_idle();
  endtask

  task automatic test_ignore_ticks();
    int ticks = 0;
    BaudTick = 1;
    step();
    step();
    ReqA = 1; DinA = 8'h77;
    step();
    ReqA = 0;
    step();
    BaudTick = 0;
    for (int i = 1; i <= 40; i++) begin
      pulse();
      if (Done) begin
        ticks = i;
        break;
      end
      step();
    end
    checks++;
    if (ticks !== 12) begin
      errors++;
      $display("FAIL ignore_ticks: Done after %0d ticks want 12", ticks);
    end
    wait_idle();
  endtask

  task automatic test_gap0();
    int ticks = 0;
    ReqB2 = 1; DinB = 8'h66;
    step();
    checks++;
    if (Load2 !== 1'b1 || GntB2 !== 1'b1 || Dout2 !== 8'h66) begin
      errors++;
      $display("FAIL gap0_load: L=%b GB=%b D=%h want 1 1 66", Load2, GntB2, Dout2);
    end
    step();
    for (int i = 1; i <= 40; i++) begin
      pulse();
      if (Done2) begin
        ticks = i;
        break;
      end
      step();
    end
    checks++;
    if (ticks !== 11 || Busy2 !== 1'b0) begin
      errors++;
      $display("FAIL gap0_done: Done after %0d ticks Busy=%b want 11 0", ticks, Busy2);
    end
    step();
    checks++;
    if (Load2 !== 1'b1 || GntB2 !== 1'b1 || Done2 !== 1'b0) begin
      errors++;
      $display("FAIL gap0_reload: L=%b GB=%b Dn=%b want 1 1 0", Load2, GntB2, Done2);
    end
    ReqB2 = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mid_frame();
    test_reset_mid();
    test_ignore_ticks();
    test_gap0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
